// File: rtl/seq_mul_pkg.sv
// Shared state encodings and limits for the sequential multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 16;

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate: o_y = i_en ? -i_a : i_a.
module twos_negate #(
    parameter int W = 8
) (
    input  logic         i_en,
    input  logic [W-1:0] i_a,
    output logic [W-1:0] o_y
);

    assign o_y = i_en ? (~i_a + W'(1)) : i_a;

endmodule

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier, one multiplier bit per clock, early exit.
// Signed mode is built only when SEQ_MUL_SIGNED_EN is defined.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic               Signed,
`endif
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product,
    output logic               Zero,
    output logic               Ovf
);

    localparam int PW = 2 * WIDTH;

    state_t           r_state;
    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_product;
    logic             r_busy;
    logic             r_done;
    logic             r_zero;
    logic             r_ovf;

    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [PW-1:0]    w_result;
    logic             w_ovf;
    logic             w_idle;
    logic             w_accept;
    logic [WIDTH-1:0] w_mplier_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_last;

    // The unused encoding 2'd3 behaves as IDLE.
    assign w_idle   = (r_state != ST_RUN) && (r_state != ST_DONE);
    assign w_accept = w_idle && Start;

    assign w_mplier_next = r_mplier >> 1;
    assign w_cnt_next    = r_cnt + CNT_W'(1);
    assign w_last        = (w_mplier_next == '0)
                        || (w_cnt_next == CNT_W'(WIDTH));

`ifdef SEQ_MUL_SIGNED_EN
    logic r_neg;
    logic r_sgn;

    twos_negate #(.W(WIDTH)) u_abs_a (
        .i_en (Signed & A[WIDTH-1]),
        .i_a  (A),
        .o_y  (w_a_abs)
    );

    twos_negate #(.W(WIDTH)) u_abs_b (
        .i_en (Signed & B[WIDTH-1]),
        .i_a  (B),
        .o_y  (w_b_abs)
    );

    twos_negate #(.W(PW)) u_fix (
        .i_en (r_neg),
        .i_a  (r_acc),
        .o_y  (w_result)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_neg <= 1'b0;
            r_sgn <= 1'b0;
        end else if (w_accept) begin
            r_sgn <= Signed;
            r_neg <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
        end
    end

    // Signed overflow: high half must be a copy of the low half's sign.
    assign w_ovf = r_sgn
        ? (w_result != {{WIDTH{w_result[WIDTH-1]}},
                        w_result[WIDTH-1:0]})
        : (|w_result[PW-1:WIDTH]);
`else
    assign w_a_abs  = A;
    assign w_b_abs  = B;
    assign w_result = r_acc;
    assign w_ovf    = |r_acc[PW-1:WIDTH];
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_zero    <= 1'b1;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= w_cnt_next;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_product <= w_result;
                    r_zero    <= (w_result == '0);
                    r_ovf     <= w_ovf;
                    r_done    <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    // Busy stays up through the Done cycle, then drops.
                    r_busy <= w_accept;
                    if (w_accept) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_abs};
                        r_mplier <= w_b_abs;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign Busy    = r_busy;
    assign Done    = r_done;
    assign Product = r_product;
    assign Zero    = r_zero;
    assign Ovf     = r_ovf;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=8), table plus corner sequences.
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zero;
    logic        ovf;
`ifdef SEQ_MUL_SIGNED_EN
    logic        sgn;
`endif

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sgn;
        logic [15:0] prod;
        logic        zero;
        logic        ovf;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    seq_multiplier #(.WIDTH(8)) dut (
        .Clock   (clk),
        .Reset   (rst),
        .Start   (start),
        .A       (a),
        .B       (b),
`ifdef SEQ_MUL_SIGNED_EN
        .Signed  (sgn),
`endif
        .Busy    (busy),
        .Done    (done),
        .Product (product),
        .Zero    (zero),
        .Ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the Done cycle.
    task automatic do_op(input vec_t v);
        int  n;
        bit  seen;
        a     = v.a;
        b     = v.b;
`ifdef SEQ_MUL_SIGNED_EN
        sgn   = v.sgn;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        n     = 0;
        seen  = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({v.nm, " latency"}, 32'(n), 32'(v.lat));
        chk({v.nm, " product"}, 32'(product), 32'(v.prod));
        chk({v.nm, " zero"}, 32'(zero), 32'(v.zero));
        chk({v.nm, " ovf"}, 32'(ovf), 32'(v.ovf));
    endtask

    initial begin
        vec_t v;
        int   nd;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SEQ_MUL_SIGNED_EN
        sgn   = 1'b0;
`endif

        vecs.push_back('{8'h1F, 8'hE3, 0, 16'h1B7D, 0, 1, 9, "1f_e3"});
        vecs.push_back('{8'h55, 8'h00, 0, 16'h0000, 1, 0, 2, "55_00"});
        vecs.push_back('{8'h55, 8'h01, 0, 16'h0055, 0, 0, 2, "55_01"});
        vecs.push_back('{8'hC8, 8'h03, 0, 16'h0258, 0, 1, 3, "c8_03"});
        vecs.push_back('{8'h0F, 8'h10, 0, 16'h00F0, 0, 0, 6, "0f_10"});
        vecs.push_back('{8'h80, 8'h80, 0, 16'h4000, 0, 1, 9, "80_80u"});
        vecs.push_back('{8'h00, 8'h7F, 0, 16'h0000, 1, 0, 8, "00_7f"});
`ifdef SEQ_MUL_SIGNED_EN
        vecs.push_back('{8'hFD, 8'h05, 1, 16'hFFF1, 0, 0, 4, "s_fd_05"});
        vecs.push_back('{8'h80, 8'h80, 1, 16'h4000, 0, 1, 9, "s_80_80"});
        vecs.push_back('{8'hFD, 8'h05, 0, 16'h04F1, 0, 1, 4, "u_fd_05"});
        vecs.push_back('{8'hFD, 8'hFB, 1, 16'h000F, 0, 0, 4, "s_fd_fb"});
        vecs.push_back('{8'h05, 8'hFF, 1, 16'hFFFB, 0, 0, 2, "s_05_ff"});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst product", 32'(product), 0);
        chk("rst zero", 32'(zero), 1);
        chk("rst ovf", 32'(ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i]);
            chk({vecs[i].nm, " busy in done"}, 32'(busy), 1);
            @(negedge clk);
            chk({vecs[i].nm, " busy after"}, 32'(busy), 0);
            chk({vecs[i].nm, " done pulse"}, 32'(done), 0);
        end

        // Start during RUN is ignored.
        a = 8'd200;
        b = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ign busy run", 32'(busy), 1);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ign done t+3", 32'(done), 1);
        chk("ign product", 32'(product), 600);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("ign no 2nd done", 32'(nd), 0);
        chk("ign product held", 32'(product), 600);
        chk("ign busy idle", 32'(busy), 0);

        // Back-to-back: next Start driven during the Done cycle.
        v = '{8'hFF, 8'hFF, 0, 16'hFE01, 0, 1, 9, "b2b_ff"};
        do_op(v);
        v = '{8'h02, 8'h02, 0, 16'h0004, 0, 0, 3, "b2b_02"};
        do_op(v);
        @(negedge clk);

        // Reset in the middle of a long run.
        a = 8'h1F;
        b = 8'hE3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid rst busy", 32'(busy), 0);
        chk("mid rst done", 32'(done), 0);
        chk("mid rst product", 32'(product), 0);
        chk("mid rst zero", 32'(zero), 1);
        chk("mid rst ovf", 32'(ovf), 0);
        rst = 1'b0;
        nd = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mid rst no done", 32'(nd), 0);
        v = '{8'h1F, 8'hE3, 0, 16'h1B7D, 0, 1, 9, "after rst"};
        do_op(v);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
